// File: rtl/bus_arbiter88.sv
// Two-master memory arbiter: core88 CPU (default owner) vs. a DMA requester.
// DMA bursts are capped at DMA_BURST cycles; the CPU always keeps at least CPU_MIN cycles between bursts.
module bus_arbiter88 #(
  parameter int DMA_BURST = 4,
  parameter int CPU_MIN   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wreq,
  output logic        cpu_locked,
  output logic [7:0]  cpu_bus,
  input  logic        dma_req,
  input  logic [19:0] dma_address,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_wreq,
  input  logic [7:0]  mem_in
);

  typedef enum logic {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

  localparam logic [8:0] CPU_MIN9   = 9'(CPU_MIN);
  localparam logic [7:0] BURST_LAST = 8'(DMA_BURST - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        run;

  // Grants are only live with a good clock and outside reset.
  assign run = pll_locked & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CPU;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts CPU cycles since the last burst in S_CPU, burst cycles in S_DMA.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (pll_locked) begin
      unique case (state)
        S_CPU: begin
          cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          if (dma_req && ({1'b0, cnt} + 9'd1 >= CPU_MIN9)) begin
            state_nxt = S_DMA;
            cnt_nxt   = 8'd0;
          end
        end
        S_DMA: begin
          if (!dma_req || cnt == BURST_LAST) begin
            state_nxt = S_CPU;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign cpu_locked  = run & (state == S_CPU);
  assign dma_ack     = run & (state == S_DMA) & dma_req;

  assign mem_address = (state == S_DMA) ? dma_address : cpu_address;
  assign mem_out     = (state == S_DMA) ? dma_wdata   : cpu_data;
  // A stalled core keeps wreq asserted; gating with cpu_locked keeps it off the bus.
  assign mem_wreq    = (state == S_DMA) ? (dma_we & dma_ack) : (cpu_wreq & cpu_locked);

  assign cpu_bus     = mem_in;
  assign dma_rdata   = mem_in;

endmodule

// File: tb/tb_bus_arbiter88.sv
// Directed bench for bus_arbiter88 (DMA_BURST=4, CPU_MIN=2) with a 1 MiB async-read memory model.
module tb_bus_arbiter88;

  logic        clock = 1'b0;
  logic        reset, pll_locked;
  logic [19:0] cpu_address, dma_address, mem_address;
  logic [7:0]  cpu_data, cpu_bus, dma_wdata, dma_rdata, mem_out, mem_in;
  logic        cpu_wreq, cpu_locked, dma_req, dma_we, dma_ack, mem_wreq;

  int tests = 0;
  int fails = 0;
  int acks, cpus;
  int wr300 = 0;
  int wr400 = 0;
  int wr500 = 0;

  logic [7:0] mem [0:1048575];

  always #5 clock = ~clock;

  bus_arbiter88 #(.DMA_BURST(4), .CPU_MIN(2)) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wreq(cpu_wreq),
    .cpu_locked(cpu_locked), .cpu_bus(cpu_bus),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_address(mem_address), .mem_out(mem_out), .mem_wreq(mem_wreq), .mem_in(mem_in)
  );

  assign mem_in = mem[mem_address];

  always @(posedge clock) begin
    if (mem_wreq) begin
      mem[mem_address] <= mem_out;
      if (mem_address == 20'h00300) wr300 <= wr300 + 1;
      if (mem_address == 20'h00400) wr400 <= wr400 + 1;
      if (mem_address == 20'h00500) wr500 <= wr500 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b1;
    cpu_wreq = 1'b1; cpu_address = 20'hF0010; cpu_data = 8'h5A;
    dma_req = 1'b0; dma_address = 20'h0; dma_wdata = 8'h0; dma_we = 1'b0;

    // reset: everything gated even with a pending CPU write
    mid;
    chk("rst_locked", 32'(cpu_locked), 32'd0);
    chk("rst_ack",    32'(dma_ack),    32'd0);
    chk("rst_wreq",   32'(mem_wreq),   32'd0);

    // CPU write 0x5A -> 0xF0010, then read back
    tick; reset = 1'b0;
    mid;
    chk("cpu_locked_run", 32'(cpu_locked),  32'd1);
    chk("cpu_wr_addr",    32'(mem_address), 32'hF0010);
    chk("cpu_wr_data",    32'(mem_out),     32'h5A);
    chk("cpu_wr_wreq",    32'(mem_wreq),    32'd1);
    tick; cpu_wreq = 1'b0;
    mid;
    chk("cpu_rd_5a", 32'(cpu_bus), 32'h5A);

    // preload 0x3C at 0x00100 through the CPU port
    tick; cpu_wreq = 1'b1; cpu_address = 20'h00100; cpu_data = 8'h3C;
    mid;

    // single DMA read: request in cycle N, ack in N+1
    tick; cpu_wreq = 1'b0; dma_req = 1'b1; dma_address = 20'h00100; dma_we = 1'b0;
    mid;
    chk("dma_n_ack",    32'(dma_ack),    32'd0);
    chk("dma_n_locked", 32'(cpu_locked), 32'd1);
    tick;
    mid;
    chk("dma_rd_ack",    32'(dma_ack),    32'd1);
    chk("dma_rd_data",   32'(dma_rdata),  32'h3C);
    chk("dma_rd_locked", 32'(cpu_locked), 32'd0);
    tick; dma_req = 1'b0;
    mid;
    chk("dma_idle_ack",    32'(dma_ack),    32'd0);
    chk("dma_idle_locked", 32'(cpu_locked), 32'd0);
    chk("dma_idle_wreq",   32'(mem_wreq),   32'd0);
    tick;
    mid;
    chk("cpu_back", 32'(cpu_locked), 32'd1);
    tick; tick;

    // steady contention: CPU, then (DMA x4, CPU x2) repeating
    tick; dma_req = 1'b1; acks = 0; cpus = 0;
    for (int i = 0; i < 20; i++) begin
      mid;
      begin
        logic e;
        e = (i >= 1) && (((i - 1) % 6) < 4);
        chk($sformatf("cont_ack_%0d", i),    32'(dma_ack),    32'(e));
        chk($sformatf("cont_locked_%0d", i), 32'(cpu_locked), 32'(!e));
      end
      acks += int'(dma_ack);
      cpus += int'(cpu_locked);
      tick;
    end
    dma_req = 1'b0;
    chk("cont_acks", 32'(acks), 32'd13);
    chk("cont_cpus", 32'(cpus), 32'd7);
    mid;
    chk("cont_end_idle", 32'(dma_ack), 32'd0);
    tick; tick; tick;

    // CPU write held while stalled by a DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 20'h00200; dma_wdata = 8'hA5;
    mid;
    chk("stall_n0_locked", 32'(cpu_locked), 32'd1);
    tick; cpu_wreq = 1'b1; cpu_address = 20'h00300; cpu_data = 8'h77;
    mid;
    chk("stall_dma_ack",  32'(dma_ack),     32'd1);
    chk("stall_dma_wreq", 32'(mem_wreq),    32'd1);
    chk("stall_dma_addr", 32'(mem_address), 32'h00200);
    chk("stall_dma_data", 32'(mem_out),     32'hA5);
    chk("stall_locked",   32'(cpu_locked),  32'd0);
    tick; dma_req = 1'b0;
    mid;
    chk("stall_idle_wreq",   32'(mem_wreq),   32'd0);
    chk("stall_idle_locked", 32'(cpu_locked), 32'd0);
    tick;
    mid;
    chk("cpu_commit_locked", 32'(cpu_locked),  32'd1);
    chk("cpu_commit_wreq",   32'(mem_wreq),    32'd1);
    chk("cpu_commit_addr",   32'(mem_address), 32'h00300);
    chk("cpu_commit_data",   32'(mem_out),     32'h77);
    tick; cpu_wreq = 1'b0; cpu_address = 20'h00200;
    mid;
    chk("rd_dma_written", 32'(cpu_bus), 32'hA5);
    chk("cpu_wr_once",    32'(wr300),   32'd1);
    cpu_address = 20'h00300;
    #1;
    chk("rd_cpu_written", 32'(cpu_bus), 32'h77);
    tick; tick;

    // pll_locked low for 3 cycles while the burst sits at cnt=2
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 20'h00400; dma_wdata = 8'h99;
    mid;
    tick;
    mid;
    chk("pll_b0_ack", 32'(dma_ack), 32'd1);
    tick;
    mid;
    chk("pll_b1_ack", 32'(dma_ack), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick; pll_locked = 1'b0;
      mid;
      chk($sformatf("pll_low_ack_%0d", k),    32'(dma_ack),    32'd0);
      chk($sformatf("pll_low_wreq_%0d", k),   32'(mem_wreq),   32'd0);
      chk($sformatf("pll_low_locked_%0d", k), 32'(cpu_locked), 32'd0);
    end
    tick; pll_locked = 1'b1;
    mid;
    chk("pll_b2_ack",  32'(dma_ack),  32'd1);
    chk("pll_b2_wreq", 32'(mem_wreq), 32'd1);
    tick;
    mid;
    chk("pll_b3_ack", 32'(dma_ack), 32'd1);
    tick;
    mid;
    chk("pll_burst_end_ack",    32'(dma_ack),    32'd0);
    chk("pll_burst_end_locked", 32'(cpu_locked), 32'd1);
    chk("pll_burst_writes",     32'(wr400),      32'd4);
    dma_req = 1'b0;
    tick; tick; tick;

    // reset in the middle of a DMA write burst
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 20'h00500; dma_wdata = 8'h11;
    mid;
    chk("rb_n0_locked", 32'(cpu_locked), 32'd1);
    tick;
    mid;
    chk("rb_first_ack", 32'(dma_ack), 32'd1);
    tick; reset = 1'b1;
    mid;
    chk("rb_rst_ack",    32'(dma_ack),    32'd0);
    chk("rb_rst_wreq",   32'(mem_wreq),   32'd0);
    chk("rb_rst_locked", 32'(cpu_locked), 32'd0);
    tick; reset = 1'b0;
    mid;
    chk("rb_cpu0_locked", 32'(cpu_locked), 32'd1);
    chk("rb_cpu0_ack",    32'(dma_ack),    32'd0);
    tick;
    mid;
    chk("rb_cpu1_locked", 32'(cpu_locked), 32'd1);
    chk("rb_cpu1_ack",    32'(dma_ack),    32'd0);
    tick;
    mid;
    chk("rb_resume_ack",    32'(dma_ack),    32'd1);
    chk("rb_resume_locked", 32'(cpu_locked), 32'd0);
    tick; dma_req = 1'b0;
    chk("rb_writes", 32'(wr500), 32'd2);
    mid;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
